// File: rtl/dsram_bridge.sv
// M-stage load/store bridge to an SRAM-like bus with split addr_ok/data_ok handshakes.
// Optional bus watchdog enabled by defining DSRAM_TIMEOUT_EN.
module dsram_bridge #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [3:0]  req_sel,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        m_hold,
  output logic [31:0] rdata,
  output logic        stall,
  output logic        bus_err,
  output logic        data_sram_req,
  output logic        data_sram_wr,
  output logic [1:0]  data_sram_size,
  output logic [31:0] data_sram_addr,
  output logic [31:0] data_sram_wdata,
  input  logic        data_sram_addr_ok,
  input  logic        data_sram_data_ok,
  input  logic [31:0] data_sram_rdata
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic        req_q, req_d;
  logic        wr_q, wr_d;
  logic [1:0]  size_q, size_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        access;

  function automatic logic [1:0] sel_to_size(input logic [3:0] sel);
    case (sel)
      4'b0001, 4'b0010, 4'b0100, 4'b1000: sel_to_size = 2'd0;
      4'b0011, 4'b1100:                   sel_to_size = 2'd1;
      default:                            sel_to_size = 2'd2;
    endcase
  endfunction

  // A request with no byte lanes is not a memory access at all.
  assign access = req_valid && (req_sel != 4'b0000);

`ifdef DSRAM_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        bus_err_q, bus_err_d;
`endif

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
`ifdef DSRAM_TIMEOUT_EN
    cnt_d     = cnt_q;
    bus_err_d = bus_err_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (access) begin
          state_d = StReq;
          req_d   = 1'b1;
          wr_d    = req_we;
          size_d  = sel_to_size(req_sel);
          addr_d  = req_addr;
          wdata_d = req_wdata;
`ifdef DSRAM_TIMEOUT_EN
          cnt_d   = '0;
`endif
        end
      end
      StReq: begin
        if (data_sram_addr_ok) begin
          req_d = 1'b0;
          if (data_sram_data_ok) begin
            state_d = StResp;
            rdata_d = wr_q ? rdata_q : data_sram_rdata;
          end else begin
            state_d = StWait;
          end
        end
      end
      StWait: begin
        if (data_sram_data_ok) begin
          state_d = StResp;
          rdata_d = wr_q ? rdata_q : data_sram_rdata;
        end
      end
      StResp: begin
        if (!m_hold) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
`ifdef DSRAM_TIMEOUT_EN
    // A real completion in the final allowed cycle wins over the abort.
    if ((state_q == StReq || state_q == StWait) && state_d != StResp) begin
      cnt_d = cnt_q + 32'd1;
      if (cnt_q == TIMEOUT - 1) begin
        state_d   = StResp;
        req_d     = 1'b0;
        rdata_d   = 32'hDEADBEEF;
        bus_err_d = 1'b1;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      req_q   <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'd0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

`ifdef DSRAM_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q     <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      bus_err_q <= bus_err_d;
    end
  end
  assign bus_err = bus_err_q;
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
  assign bus_err        = 1'b0;
`endif

  assign stall           = (state_q == StIdle && access) || state_q == StReq || state_q == StWait;
  assign rdata           = rdata_q;
  assign data_sram_req   = req_q;
  assign data_sram_wr    = wr_q;
  assign data_sram_size  = size_q;
  assign data_sram_addr  = addr_q;
  assign data_sram_wdata = wdata_q;

endmodule

// File: tb/tb_dsram_bridge.sv
// Directed, table-driven bench for dsram_bridge with a cycle-indexed bus model.
module tb_dsram_bridge;

  localparam int unsigned Tmo = 8;

  logic        clk, rst;
  logic        req_valid, req_we, m_hold;
  logic [3:0]  req_sel;
  logic [31:0] req_addr, req_wdata;
  logic [31:0] rdata;
  logic        stall, bus_err;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_rdata = 32'h0;

  dsram_bridge #(.TIMEOUT(Tmo)) dut (
    .clk               (clk),
    .rst               (rst),
    .req_valid         (req_valid),
    .req_we            (req_we),
    .req_sel           (req_sel),
    .req_addr          (req_addr),
    .req_wdata         (req_wdata),
    .m_hold            (m_hold),
    .rdata             (rdata),
    .stall             (stall),
    .bus_err           (bus_err),
    .data_sram_req     (data_sram_req),
    .data_sram_wr      (data_sram_wr),
    .data_sram_size    (data_sram_size),
    .data_sram_addr    (data_sram_addr),
    .data_sram_wdata   (data_sram_wdata),
    .data_sram_addr_ok (data_sram_addr_ok),
    .data_sram_data_ok (data_sram_data_ok),
    .data_sram_rdata   (data_sram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  sel;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          addr_lat;  // REQ cycles, addr_ok on the last one
    int          data_lat;  // cycles from addr_ok to data_ok
    int          hold;      // RESP cycles with m_hold=1
    logic [1:0]  size;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rdata"}, rdata, 32'h0);
    check({tag, " stall"}, {31'b0, stall}, 32'h0);
    check({tag, " bus_err"}, {31'b0, bus_err}, 32'h0);
    check({tag, " req"}, {31'b0, data_sram_req}, 32'h0);
    check({tag, " wr"}, {31'b0, data_sram_wr}, 32'h0);
    check({tag, " size"}, {30'b0, data_sram_size}, 32'h0);
    check({tag, " addr"}, data_sram_addr, 32'h0);
    check({tag, " wdata"}, data_sram_wdata, 32'h0);
  endtask

  // Starts #1 after a rising edge with the bridge idle; ends the same way.
  task automatic run_access(input int idx, input vec_t v);
    int total;
    logic [31:0] prev;
    total = v.addr_lat + v.data_lat;
    prev  = exp_rdata;
    for (int k = 0; k <= total + v.hold + 2; k++) begin
      req_valid         = (k <= total + v.hold + 1);
      req_sel           = v.sel;
      req_we            = v.we;
      req_addr          = v.addr;
      req_wdata         = v.wdata;
      m_hold            = (k > total) && (k <= total + v.hold);
      data_sram_addr_ok = (k == v.addr_lat);
      data_sram_data_ok = (k == total);
      data_sram_rdata   = (k == total) ? v.rd : (32'h5A5A0000 ^ k);
      @(negedge clk);
      check($sformatf("v%0d k%0d stall", idx, k), {31'b0, stall}, {31'b0, k <= total});
      check($sformatf("v%0d k%0d req", idx, k), {31'b0, data_sram_req},
            {31'b0, (k >= 1) && (k <= v.addr_lat)});
      if (k >= 1 && k <= v.addr_lat) begin
        check($sformatf("v%0d k%0d addr", idx, k), data_sram_addr, v.addr);
        check($sformatf("v%0d k%0d wr", idx, k), {31'b0, data_sram_wr}, {31'b0, v.we});
        check($sformatf("v%0d k%0d size", idx, k), {30'b0, data_sram_size}, {30'b0, v.size});
        check($sformatf("v%0d k%0d wdata", idx, k), data_sram_wdata, v.wdata);
      end
      exp_rdata = (k > total && !v.we) ? v.rd : prev;
      check($sformatf("v%0d k%0d rdata", idx, k), rdata, exp_rdata);
      @(posedge clk);
      #1;
    end
    data_sram_addr_ok = 1'b0;
    data_sram_data_ok = 1'b0;
  endtask

  initial begin
    vecs[0] = '{4'b1111, 1'b0, 32'h0000_0104, 32'h0, 32'h1234_5678, 1, 1, 0, 2'd2};
    vecs[1] = '{4'b0100, 1'b1, 32'h0000_0206, 32'h00AB_0000, 32'hFFFF_FFFF, 1, 0, 0, 2'd0};
    vecs[2] = '{4'b1111, 1'b0, 32'h0000_0200, 32'h0, 32'hCAFE_F00D, 1, 1, 4, 2'd2};
    vecs[3] = '{4'b0011, 1'b0, 32'h0000_1002, 32'h0, 32'h0000_BEEF, 5, 7, 0, 2'd1};
    vecs[4] = '{4'b1100, 1'b1, 32'h0000_2002, 32'h1357_0000, 32'h1111_1111, 2, 0, 0, 2'd1};
    vecs[5] = '{4'b0001, 1'b0, 32'h0000_3001, 32'h0, 32'h0000_00A5, 1, 2, 1, 2'd0};
    vecs[6] = '{4'b1000, 1'b0, 32'h0000_3003, 32'h0, 32'hC300_0000, 3, 0, 0, 2'd0};
    vecs[7] = '{4'b0110, 1'b0, 32'h0000_4000, 32'h0, 32'h0BAD_CAFE, 1, 1, 0, 2'd2};
    vecs[8] = '{4'b0101, 1'b1, 32'h0000_5000, 32'h00FF_00FF, 32'h2222_2222, 3, 1, 0, 2'd2};
    vecs[9] = '{4'b0111, 1'b0, 32'h0000_6000, 32'h0, 32'h7654_3210, 1, 1, 2, 2'd2};

    req_valid = 1'b0; req_we = 1'b0; req_sel = 4'h0; req_addr = '0; req_wdata = '0;
    m_hold = 1'b0; data_sram_addr_ok = 1'b0; data_sram_data_ok = 1'b0; data_sram_rdata = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < 10; i++) begin
`ifdef DSRAM_TIMEOUT_EN
      if (vecs[i].addr_lat + vecs[i].data_lat > Tmo) continue;
`endif
      run_access(i, vecs[i]);
    end

    // Zero byte lanes: no stall, no request. A stray data_ok in IDLE is ignored.
    req_valid = 1'b1; req_sel = 4'b0000; req_addr = 32'h0000_9000;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'hABCD_ABCD;
    @(negedge clk);
    check("nosel stall", {31'b0, stall}, 32'h0);
    @(posedge clk); #1;
    req_valid = 1'b0; data_sram_data_ok = 1'b0;
    @(negedge clk);
    check("nosel req", {31'b0, data_sram_req}, 32'h0);
    check("idle data_ok rdata", rdata, exp_rdata);
    @(posedge clk); #1;

    // Reset while waiting for data, then a stale data_ok.
    req_valid = 1'b1; req_sel = 4'b1111; req_we = 1'b0; req_addr = 32'h0000_0300;
    @(posedge clk); #1;
    data_sram_addr_ok = 1'b1;
    @(posedge clk); #1;
    data_sram_addr_ok = 1'b0;
    @(negedge clk);
    check("rst pre stall", {31'b0, stall}, 32'h1);
    check("rst pre req", {31'b0, data_sram_req}, 32'h0);
    #2;
    rst = 1'b0; req_valid = 1'b0;
    #1;
    check_reset_outputs("rst async");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    data_sram_data_ok = 1'b1; data_sram_rdata = 32'h7777_7777;
    @(negedge clk);
    check("stale rdata", rdata, 32'h0);
    check("stale stall", {31'b0, stall}, 32'h0);
    @(posedge clk); #1;
    data_sram_data_ok = 1'b0;
    @(negedge clk);
    check_reset_outputs("post stale");
    exp_rdata = 32'h0;
    @(posedge clk); #1;

`ifdef DSRAM_TIMEOUT_EN
    for (int k = 0; k <= Tmo + 2; k++) begin
      req_valid = (k <= Tmo + 1); req_sel = 4'b1111; req_we = 1'b0; req_addr = 32'h0000_0400;
      m_hold = 1'b0;
      @(negedge clk);
      check($sformatf("tmo k%0d stall", k), {31'b0, stall}, {31'b0, k <= Tmo});
      check($sformatf("tmo k%0d req", k), {31'b0, data_sram_req},
            {31'b0, (k >= 1) && (k <= Tmo)});
      if (k == Tmo + 1) begin
        check("tmo rdata", rdata, 32'hDEADBEEF);
        check("tmo bus_err", {31'b0, bus_err}, 32'h1);
      end
      @(posedge clk); #1;
    end
    exp_rdata = 32'hDEADBEEF;
    run_access(100, vecs[0]);
    check("tmo bus_err sticky", {31'b0, bus_err}, 32'h1);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dsram_bridge.md
# dsram_bridge

Memory-stage data bridge between the pipeline's M-stage load/store request (address, store data, byte select, memory enable) and an SRAM-like data bus with split address/data handshakes. It issues one transaction per M-stage memory instruction, stalls the pipeline until the bus answers, and returns a registered load word for the M-stage result mux. It also holds the completed result while the pipeline cannot advance, so no access is ever issued twice.

## Interface
Parameters:
- TIMEOUT, default 64: cycles allowed in REQ+WAIT before abort; only used with DSRAM_TIMEOUT_EN.

Ports:
- clk  in  1  pipeline clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  M-stage memory enable.
- req_we  in  1  1 = store, 0 = load.
- req_sel  in  4  byte lanes (store byte enables / load lanes).
- req_addr  in  32  byte address from the M-stage ALU result.
- req_wdata  in  32  lane-aligned store data.
- m_hold  in  1  M stage will not advance at the end of this cycle.
- rdata  out  32  captured load word, registered.
- stall  out  1  to the hazard unit; freezes F/D/E/M.
- bus_err  out  1  sticky timeout flag.
- data_sram_req  out  1  bus request.
- data_sram_wr  out  1  bus write.
- data_sram_size  out  2  0 = byte, 1 = half, 2 = word.
- data_sram_addr  out  32  bus address.
- data_sram_wdata  out  32  bus write data.
- data_sram_addr_ok  in  1  address accepted.
- data_sram_data_ok  in  1  read data valid / write done.
- data_sram_rdata  in  32  read data.

## Operation
- FSM states: IDLE, REQ, WAIT, RESP.
- An access is a request with req_valid=1 and req_sel≠0. req_valid with req_sel=0 is ignored: no transaction, no stall.
- IDLE, access present: latch addr, wdata, we, size into the bus registers, go to REQ.
- REQ: data_sram_req=1.
  - addr_ok=0: stay in REQ.
  - addr_ok=1 and data_ok=0: go to WAIT.
  - addr_ok=1 and data_ok=1: capture data, go to RESP.
- WAIT: data_sram_req=0. On data_ok, capture rdata (load) or keep the previous value (store), then go to RESP.
- RESP: stall=0.
  - m_hold=0: go to IDLE.
  - m_hold=1: stay in RESP; rdata is held and no new request is issued.
- stall = (IDLE and access) or REQ or WAIT. stall is combinational from req_valid/req_sel in IDLE only.
- Size mapping:
  - req_sel 1111 → 2.
  - 0011 or 1100 → 1.
  - One-hot → 0.
  - Any other nonzero pattern → 2.
- data_sram_addr = req_addr unmodified. data_sram_wr = req_we.
- data_ok arriving in IDLE or RESP is discarded.
- At most one outstanding transaction.

## Timing
- Reset values: state IDLE, data_sram_req 0, data_sram_wr 0, data_sram_size 0, data_sram_addr 0, data_sram_wdata 0, rdata 0, stall 0, bus_err 0.
- Minimum access sequence (addr_ok in REQ, data_ok the next cycle):
  - cycle 0: IDLE, stall=1.
  - cycle 1: REQ.
  - cycle 2: WAIT, data_ok.
  - cycle 3: RESP, stall=0, rdata valid.
  - Total: 3 stall cycles.
- With addr_ok and data_ok together in REQ: 2 stall cycles.
- Bus outputs are registered; address and data stay stable from REQ entry until addr_ok.
- Reset mid-transaction returns to IDLE immediately. A later data_ok from the aborted access is discarded.
- Back-to-back accesses: RESP→IDLE, then the next access starts a cycle later. One idle bubble on the bus.

## Configuration
- DSRAM_TIMEOUT_EN defined:
  - A counter clears on REQ entry and increments each cycle in REQ or WAIT.
  - When it reaches TIMEOUT: go to RESP, set rdata=32'hDEADBEEF, set bus_err=1, drop data_sram_req.
  - bus_err is cleared only by reset.
- DSRAM_TIMEOUT_EN not defined: no counter, bus_err tied 0, the bridge waits indefinitely.

## Test plan
- Load word: sel=1111, addr=0x00000104; addr_ok in REQ, data_ok next cycle with 0x12345678 → size=2, stall high 3 cycles, rdata=0x12345678 in RESP.
- Store byte: we=1, sel=0100, wdata=0x00AB0000; addr_ok and data_ok in the same cycle → wr=1, size=0, stall high 2 cycles, rdata unchanged.
- Hold: load completes while m_hold=1 for 4 cycles → single data_sram_req pulse, stall=0, rdata stable across all 4 cycles, then IDLE.
- Slow bus: addr_ok delayed 5 cycles, then data_ok 7 cycles later → addr and req stable throughout, stall high 13 cycles.
- Reset: assert rst low while in WAIT, release, then inject a stale data_ok → state IDLE, all outputs at reset values, rdata stays 0.
- With DSRAM_TIMEOUT_EN and TIMEOUT=8, no addr_ok ever → RESP after 8 cycles, rdata=0xDEADBEEF, bus_err=1 and still set after the next access.
